fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the fetch stage and IF/ID pipe register. It owns the program counter and decides each cycle whether the fetch stage issues an instruction read. It also arbitrates the single-port memory between instruction fetch and data access, and drives the IF/ID enable and flush. It sits between the execute/hazard logic, which supplies redirect and stall requests, and the fetch stage plus IF/ID pipe.

## Interface
Parameters:
- REGI_BITS, 4, register-index width (passed through to the fetch stage; not used internally)
- REGI_SIZE, 16, datapath, PC and counter width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- branch_taken_i  in  1  redirect request from execute
- branch_target_i  in  REGI_SIZE  redirect address; valid when branch_taken_i=1
- stall_i  in  1  downstream hazard stall; IF/ID must hold
- halt_i  in  1  halt instruction reached decode
- dmem_req_i  in  1  data-side request for the shared memory
- pc_o  out  REGI_SIZE  address to fetch; registered; this is next_pc_i of the fetch stage
- imem_en_o  out  1  instruction read issued at pc_o this cycle
- dmem_gnt_o  out  1  data access owns the memory this cycle
- ifid_en_o  out  1  IF/ID pipe register loads this edge
- ifid_flush_o  out  1  IF/ID loads a bubble (NOP) instead of the fetched word
- halted_o  out  1  controller is in HALT
- stall_cnt_o  out  REGI_SIZE  lost-fetch cycle counter, saturating

## Operation
States: IDLE, RUN, HALT. Reset places the block in IDLE.
- IDLE: lasts exactly one cycle after reset deasserts, then moves to RUN. No fetch (imem_en_o=0). dmem_gnt_o=0. ifid_en_o=1 and ifid_flush_o=1.
- RUN: priority per cycle is branch_taken_i > halt_i > dmem_req_i > stall_i > normal fetch.
  - Branch: pc_o <= branch_target_i, imem_en_o=0, ifid_en_o=1, ifid_flush_o=1. Overrides stall_i. halt_i in the same cycle is ignored (wrong-path instruction).
  - Halt: next state is HALT. pc_o holds. imem_en_o=0. The flush rule below still applies.
  - dmem_req_i: dmem_gnt_o=1, imem_en_o=0, pc_o holds.
  - stall_i: imem_en_o=0, ifid_en_o=0, pc_o holds.
  - Normal: imem_en_o=1, pc_o <= pc_o+1.
- HALT: no fetches. pc_o holds. dmem_gnt_o=dmem_req_i. ifid_en_o=!stall_i, ifid_flush_o=ifid_en_o. Only reset exits this state.
- General rules in RUN:
  - ifid_en_o = !stall_i | branch_taken_i
  - ifid_flush_o = ifid_en_o & !imem_en_o
- PC arithmetic: word addressed, modulo 2^REGI_SIZE, so 0xFFFF+1 wraps to 0x0000.
- dmem_gnt_o = dmem_req_i in RUN and HALT; it is 0 in IDLE. The data side always wins over fetch.
- stall_cnt_o increments in RUN on cycles with no branch where imem_en_o=0 because of dmem_req_i or stall_i. It saturates at all-ones and resets only via rst_i.
- halted_o = (state==HALT).

## Timing
- Reset values (asynchronous, immediate on rst_i): state=IDLE, pc_o=RESET_PC, stall_cnt_o=0, halted_o=0, imem_en_o=0, dmem_gnt_o=0, ifid_en_o=1, ifid_flush_o=1.
- Reset asserted mid-operation: all registers return to reset values immediately, independent of clk_i. No partial PC update occurs.
- Control outputs (imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o) are combinational from the current state and inputs, within the same cycle.
- pc_o, state, halted_o and stall_cnt_o update on the edge following the deciding cycle.
- First fetch: imem_en_o=1 in the second cycle after reset release, at pc_o=RESET_PC.
- Redirect latency: a branch in cycle N yields a fetch at branch_target_i in cycle N+1, unless dmem_req_i or stall_i applies in N+1.
- halt_i in cycle N: halted_o=1 from cycle N+1.

## Test plan
- Reset release with RESET_PC=0x0010 and no requests -> IDLE for one cycle, then fetches at 0x0010, 0x0011, 0x0012 on consecutive cycles with imem_en_o=1 and no flush.
- dmem_req_i high for 2 cycles at pc_o=0x0005 -> dmem_gnt_o=1 and imem_en_o=0 for both cycles, two flushes, pc_o stays 0x0005, stall_cnt_o=2, then fetch resumes at 0x0005.
- stall_i and branch_taken_i high together with target 0x0100 -> flush, ifid_en_o=1, next pc_o=0x0100, stall_cnt_o unchanged.
- PC at 0xFFFF with normal fetch -> next pc_o=0x0000.
- halt_i at pc_o=0x0020, then dmem_req_i pulses -> halted_o=1 next cycle, no further fetches, dmem_gnt_o follows dmem_req_i, pc_o stays 0x0020. halt_i together with a branch instead -> redirect taken, halted_o stays 0.
- rst_i asserted asynchronously during a dmem stall with stall_cnt_o=7 -> pc_o=RESET_PC and stall_cnt_o=0 immediately, without waiting for a clock edge. Holding stall_i for 70000 cycles -> stall_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the program counter, arbitrates the shared
// memory between fetch and data access, and steers the IF/ID pipe register.
module fetch_ctrl #(
  parameter int                    REGI_BITS = 4,
  parameter int                    REGI_SIZE = 16,
  parameter logic [REGI_SIZE-1:0]  RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 branch_taken_i,
  input  logic [REGI_SIZE-1:0] branch_target_i,
  input  logic                 stall_i,
  input  logic                 halt_i,
  input  logic                 dmem_req_i,
  output logic [REGI_SIZE-1:0] pc_o,
  output logic                 imem_en_o,
  output logic                 dmem_gnt_o,
  output logic                 ifid_en_o,
  output logic                 ifid_flush_o,
  output logic                 halted_o,
  output logic [REGI_SIZE-1:0] stall_cnt_o
);

  // REGI_BITS only travels through to the fetch stage; it is sanity-checked here.
  if (REGI_BITS < 1) begin : g_bad_regi_bits
    $error("fetch_ctrl: REGI_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [REGI_SIZE-1:0] pc_next;
  logic                 cnt_inc;
  logic                 fetch_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state   = state;
    pc_next      = pc_o;
    cnt_inc      = 1'b0;
    fetch_ok     = 1'b0;
    imem_en_o    = 1'b0;
    dmem_gnt_o   = 1'b0;
    ifid_en_o    = 1'b1;
    ifid_flush_o = 1'b1;

    unique case (state)
      S_IDLE: begin
        next_state = S_RUN;
      end

      S_RUN: begin
        // Priority: branch > halt > data access > stall > fetch.
        fetch_ok     = !branch_taken_i && !halt_i && !dmem_req_i && !stall_i;
        imem_en_o    = fetch_ok;
        dmem_gnt_o   = dmem_req_i;
        ifid_en_o    = !stall_i || branch_taken_i;
        ifid_flush_o = ifid_en_o && !fetch_ok;

        if (branch_taken_i) begin
          pc_next = branch_target_i;
        end else if (halt_i) begin
          next_state = S_HALT;
        end else if (dmem_req_i || stall_i) begin
          cnt_inc = 1'b1;
        end else begin
          pc_next = pc_o + 1'b1;
        end
      end

      S_HALT: begin
        dmem_gnt_o   = dmem_req_i;
        ifid_en_o    = !stall_i;
        ifid_flush_o = !stall_i;
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      pc_o        <= RESET_PC;
      stall_cnt_o <= '0;
    end else begin
      state <= next_state;
      pc_o  <= pc_next;
      if (cnt_inc && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

  assign halted_o = (state == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_taken_i = 1'b0;
  logic [15:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        dmem_req_i = 1'b0;
  logic [15:0] pc_o;
  logic        imem_en_o;
  logic        dmem_gnt_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        halted_o;
  logic [15:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = waiting after reset, 1 = running, 2 = halted.
  int          m_phase;
  logic [15:0] m_pc;
  int          m_cnt;

  fetch_ctrl #(
    .REGI_BITS (4),
    .REGI_SIZE (16),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .dmem_req_i      (dmem_req_i),
    .pc_o            (pc_o),
    .imem_en_o       (imem_en_o),
    .dmem_gnt_o      (dmem_gnt_o),
    .ifid_en_o       (ifid_en_o),
    .ifid_flush_o    (ifid_flush_o),
    .halted_o        (halted_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RST_PC;
    m_cnt   = 0;
  endtask

  // Holds reset over one rising edge, checks the reset outputs, then releases.
  task automatic do_reset();
    rst_i = 1'b1;
    branch_taken_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0; dmem_req_i = 1'b0;
    @(posedge clk_i); #1;
    tests++;
    if ({pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o}
        !== {RST_PC, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: pc=%h cnt=%h halted=%b imem=%b gnt=%b en=%b fl=%b, want pc=%h cnt=0 halted=0 imem=0 gnt=0 en=1 fl=1",
               pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o, RST_PC);
    end
    rst_i = 1'b0;
    model_reset();
  endtask

  // One clock cycle: apply inputs, compare every output mid-cycle, advance model.
  task automatic step(input logic br, input logic [15:0] tgt, input logic st,
                      input logic ht, input logic dm);
    logic e_imem, e_gnt, e_en, e_fl;
    branch_taken_i = br; branch_target_i = tgt; stall_i = st; halt_i = ht; dmem_req_i = dm;
    #3;
    if (m_phase == 0) begin
      e_imem = 1'b0; e_gnt = 1'b0; e_en = 1'b1; e_fl = 1'b1;
    end else if (m_phase == 2) begin
      e_imem = 1'b0; e_gnt = dm; e_en = !st; e_fl = !st;
    end else begin
      e_imem = !br && !ht && !dm && !st;
      e_gnt  = dm;
      e_en   = !st || br;
      e_fl   = e_en && !e_imem;
    end
    tests++;
    if ({pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o}
        !== {m_pc, m_cnt[15:0], (m_phase == 2), e_imem, e_gnt, e_en, e_fl}) begin
      fails++;
      $display("FAIL cycle@%0t: pc=%h cnt=%h halted=%b imem=%b gnt=%b en=%b fl=%b, want pc=%h cnt=%h halted=%b imem=%b gnt=%b en=%b fl=%b",
               $time, pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o,
               m_pc, m_cnt[15:0], (m_phase == 2), e_imem, e_gnt, e_en, e_fl);
    end
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (br)             m_pc = tgt;
      else if (ht)        m_phase = 2;
      else if (dm || st)  m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      else                m_pc = m_pc + 16'd1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic nop();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [15:0] tgt);
    step(1'b1, tgt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    nop();                        // IDLE cycle
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (pc_o !== RST_PC + 16'(i) || imem_en_o !== 1'b1 || ifid_flush_o !== 1'b0) begin
        fails++;
        $display("FAIL first_fetch[%0d]: pc=%h imem=%b fl=%b, want pc=%h imem=1 fl=0",
                 i, pc_o, imem_en_o, ifid_flush_o, RST_PC + 16'(i));
      end
      nop();
    end
  endtask

  task automatic test_dmem();
    int cnt0;
    jump(16'h0005);
    cnt0 = m_cnt;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (pc_o !== 16'h0005 || stall_cnt_o !== 16'(cnt0 + 2)) begin
      fails++;
      $display("FAIL dmem_hold: pc=%h cnt=%h, want pc=0005 cnt=%h", pc_o, stall_cnt_o, 16'(cnt0 + 2));
    end
    nop();
    nop();
  endtask

  task automatic test_branch_stall();
    int cnt0;
    cnt0 = m_cnt;
    step(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
    tests++;
    if (pc_o !== 16'h0100 || stall_cnt_o !== 16'(cnt0)) begin
      fails++;
      $display("FAIL branch_over_stall: pc=%h cnt=%h, want pc=0100 cnt=%h", pc_o, stall_cnt_o, 16'(cnt0));
    end
    nop();
  endtask

  task automatic test_wrap();
    jump(16'hFFFF);
    nop();
    tests++;
    if (pc_o !== 16'h0000) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h, want 0000", pc_o);
    end
    nop();
  endtask

  task automatic test_halt();
    jump(16'h0020);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 16'h0, 1'(i % 3 == 0), 1'b0, 1'(i % 2));
    tests++;
    if (halted_o !== 1'b1 || pc_o !== 16'h0020) begin
      fails++;
      $display("FAIL halt_hold: halted=%b pc=%h, want halted=1 pc=0020", halted_o, pc_o);
    end
    do_reset();
    nop();
    step(1'b1, 16'h0030, 1'b0, 1'b1, 1'b0);
    nop();
    tests++;
    if (halted_o !== 1'b0 || pc_o !== 16'h0031) begin
      fails++;
      $display("FAIL branch_beats_halt: halted=%b pc=%h, want halted=0 pc=0031", halted_o, pc_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    nop();
    nop();
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    dmem_req_i = 1'b1;
    #2;
    tests++;
    if (stall_cnt_o !== 16'd7) begin
      fails++;
      $display("FAIL pre_reset_cnt: cnt=%h, want 0007", stall_cnt_o);
    end
    rst_i = 1'b1;                 // mid-cycle, clock is low-to-high far away
    #1;
    tests++;
    if ({pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o}
        !== {RST_PC, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL async_reset: pc=%h cnt=%h halted=%b imem=%b gnt=%b en=%b fl=%b, want pc=%h cnt=0 halted=0 imem=0 gnt=0 en=1 fl=1",
               pc_o, stall_cnt_o, halted_o, imem_en_o, dmem_gnt_o, ifid_en_o, ifid_flush_o, RST_PC);
    end
    do_reset();
    nop();
  endtask

  task automatic test_random();
    logic br, st, dm;
    logic [15:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      br  = ($urandom_range(7) == 0);
      st  = ($urandom_range(3) == 0);
      dm  = ($urandom_range(3) == 0);
      tgt = 16'($urandom);
      step(br, tgt, st, 1'b0, dm);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)));
  endtask

  task automatic test_saturation();
    do_reset();
    nop();
    for (int i = 0; i < 65540; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (stall_cnt_o !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_cnt_saturate: cnt=%h, want ffff", stall_cnt_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dmem();
    test_branch_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
